// File: rtl/vga_4bit_fetch_pkg.sv
// Shared constants for the 4-bit VGA frame-buffer fetch path: register map,
// control/status bit positions, FSM encoding and default geometry.
package vga_4bit_fetch_pkg;

    localparam int DEF_FB_WORDS   = 38400;
    localparam int DEF_BURST      = 8;
    localparam int DEF_FIFO_DEPTH = 256;
    localparam int DEF_USEDW_W    = 9;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_BASE   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_FRAMES = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_LATE_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_CLEAR = 3'd3,
        ST_FETCH = 3'd4,
        ST_DRAIN = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/vga_4bit_fetch_regs.sv
// Avalon-MM control/status slave: enable, frame base, sticky late flag
// (write-1-to-clear) and the frame counter, read with one cycle of latency.
module vga_4bit_fetch_regs
    import vga_4bit_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  i_address,
    input  logic        i_write,
    input  logic        i_read,
    input  logic [31:0] i_writedata,
    output logic [31:0] o_readdata,
    input  logic        i_busy,
    input  logic        i_late_set,
    input  logic        i_frame_inc,
    output logic        o_enable,
    output logic [31:0] o_base
);

    logic        r_enable;
    logic [31:0] r_base;
    logic        r_late;
    logic [15:0] r_frames;
    logic [31:0] r_readdata;
    logic [31:0] w_rdmux;

    always_comb begin
        w_rdmux = '0;
        case (i_address)
            REG_CTRL:   w_rdmux[CTRL_EN_BIT] = r_enable;
            REG_BASE:   w_rdmux = r_base;
            REG_STATUS: begin
                w_rdmux[STAT_BUSY_BIT] = i_busy;
                w_rdmux[STAT_LATE_BIT] = r_late;
            end
            default:    w_rdmux[15:0] = r_frames;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable   <= 1'b0;
            r_base     <= '0;
            r_late     <= 1'b0;
            r_frames   <= '0;
            r_readdata <= '0;
        end else begin
            if (i_write && i_address == REG_CTRL)
                r_enable <= i_writedata[CTRL_EN_BIT];
            if (i_write && i_address == REG_BASE)
                r_base <= {i_writedata[31:2], 2'b00};
            // A new late event wins over a simultaneous clear.
            if (i_late_set)
                r_late <= 1'b1;
            else if (i_write && i_address == REG_STATUS && i_writedata[STAT_LATE_BIT])
                r_late <= 1'b0;
            if (i_frame_inc)
                r_frames <= r_frames + 16'd1;
            if (i_read)
                r_readdata <= w_rdmux;
        end
    end

    assign o_readdata = r_readdata;
    assign o_enable   = r_enable;
    assign o_base     = r_base;

endmodule

// File: rtl/vga_4bit_fetch.sv
// Frame-buffer fetch controller: credit-limited Avalon-MM burst reads into the
// pixel FIFO, realigned to every frame on the falling edge of vsync_n.
module vga_4bit_fetch
    import vga_4bit_fetch_pkg::*;
#(
    parameter int FB_WORDS   = DEF_FB_WORDS,
    parameter int BURST      = DEF_BURST,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int USEDW_W    = DEF_USEDW_W
)(
    input  logic               vga_clk,
    input  logic               reset,
    input  logic [1:0]         avs_address,
    input  logic               avs_write,
    input  logic               avs_read,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic [31:0]        avm_address,
    output logic               avm_read,
    output logic [6:0]         avm_burstcount,
    input  logic               avm_waitrequest,
    input  logic [31:0]        avm_readdata,
    input  logic               avm_readdatavalid,
    output logic               fifo_write,
    output logic [31:0]        fifo_writedata,
    input  logic [USEDW_W-1:0] fifo_wrusedw,
    output logic               fifo_clear,
    input  logic               vsync_n
);

    localparam int OUT_W = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int REQ_W = $clog2(FB_WORDS + 1);
    localparam logic [OUT_W-1:0] BURST_O   = OUT_W'(BURST);
    localparam logic [REQ_W-1:0] BURST_R   = REQ_W'(BURST);
    localparam logic [REQ_W-1:0] FB_END    = REQ_W'(FB_WORDS);
    localparam logic [31:0]      ADDR_STEP = 32'(4 * BURST);

    fetch_state_t     r_state;
    logic             r_vs_q1, r_vs_q2;
    logic             r_avm_read;
    logic [31:0]      r_addr;
    logic [OUT_W-1:0] r_out;
    logic [REQ_W-1:0] r_req;
    logic             r_fifo_clear;

    logic             w_enable;
    logic [31:0]      w_base;
    logic             w_busy;
    logic             w_frame_start;
    logic             w_accept;
    logic             w_out_idle;
    logic             w_credit;
    logic             w_can_issue;
    logic             w_late_set;
    logic             w_discard;
    logic [OUT_W-1:0] w_out_next;

    vga_4bit_fetch_regs u_regs (
        .clk         (vga_clk),
        .reset       (reset),
        .i_address   (avs_address),
        .i_write     (avs_write),
        .i_read      (avs_read),
        .i_writedata (avs_writedata),
        .o_readdata  (avs_readdata),
        .i_busy      (w_busy),
        .i_late_set  (w_late_set),
        .i_frame_inc (r_state == ST_CLEAR),
        .o_enable    (w_enable),
        .o_base      (w_base)
    );

    assign w_frame_start = r_vs_q2 & ~r_vs_q1;
    assign w_accept      = r_avm_read & ~avm_waitrequest;
    // A request still held under waitrequest counts as in flight.
    assign w_out_idle    = (r_out == '0) & ~r_avm_read;
    assign w_credit      = (32'(fifo_wrusedw) + 32'(r_out) + 32'(BURST)) <= 32'(FIFO_DEPTH);
    assign w_can_issue   = (r_state == ST_FETCH) & w_enable & ~w_frame_start &
                           (r_req != FB_END) & w_credit & ~r_avm_read;
    assign w_late_set    = w_enable & w_frame_start &
                           ((r_state == ST_FETCH) | (r_state == ST_DRAIN));
    assign w_busy        = (r_state != ST_IDLE) & (r_state != ST_SYNC);
    assign w_discard     = reset | ~w_enable | (r_state == ST_IDLE) | (r_state == ST_FLUSH);

    always_comb begin
        w_out_next = r_out;
        if (w_accept)
            w_out_next = w_out_next + BURST_O;
        if (avm_readdatavalid && r_out != '0)
            w_out_next = w_out_next - OUT_W'(1);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_vs_q1      <= 1'b0;
            r_vs_q2      <= 1'b0;
            r_avm_read   <= 1'b0;
            r_addr       <= '0;
            r_out        <= '0;
            r_req        <= '0;
            r_fifo_clear <= 1'b0;
        end else begin
            r_vs_q1      <= vsync_n;
            r_vs_q2      <= r_vs_q1;
            r_out        <= w_out_next;
            r_fifo_clear <= 1'b0;

            // Keep the request stable until accepted; re-evaluate credit a cycle later.
            if (!(r_avm_read && avm_waitrequest))
                r_avm_read <= w_can_issue;

            if (r_state == ST_CLEAR) begin
                r_addr <= {w_base[31:2], 2'b00};
                r_req  <= '0;
            end else if (w_accept) begin
                r_addr <= r_addr + ADDR_STEP;
                r_req  <= r_req + BURST_R;
            end

            if (!w_enable) begin
                if (w_out_idle)
                    r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:  r_state <= ST_SYNC;
                    ST_SYNC:  if (w_frame_start) r_state <= ST_FLUSH;
                    ST_FLUSH: if (w_out_idle) begin
                        r_state      <= ST_CLEAR;
                        r_fifo_clear <= 1'b1;
                    end
                    ST_CLEAR: r_state <= ST_FETCH;
                    ST_FETCH: begin
                        if (w_frame_start)        r_state <= ST_FLUSH;
                        else if (r_req == FB_END) r_state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (w_frame_start)        r_state <= ST_FLUSH;
                        else if (r_out == '0)     r_state <= ST_SYNC;
                    end
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign avm_address    = r_addr;
    assign avm_read       = r_avm_read;
    assign avm_burstcount = 7'(BURST);
    assign fifo_write     = avm_readdatavalid & ~w_discard;
    assign fifo_writedata = avm_readdata;
    assign fifo_clear     = r_fifo_clear;

endmodule

// File: tb/tb_vga_4bit_fetch.sv
// Self-checking bench for vga_4bit_fetch: register vector table, directed frame
// scenarios and randomized slave timing against a frame/address reference model.
module tb_vga_4bit_fetch;
    import vga_4bit_fetch_pkg::*;

    localparam int FBW = 64;
    localparam int BST = 8;
    localparam int DEP = 256;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0, avs_read = 1'b0;
    logic [31:0] avs_writedata = '0, avs_readdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [6:0]  avm_burstcount;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        fifo_write;
    logic [31:0] fifo_writedata;
    logic [8:0]  fifo_wrusedw = '0;
    logic        fifo_clear;
    logic        vsync_n = 1'b1;

    vga_4bit_fetch #(.FB_WORDS(FBW), .BURST(BST), .FIFO_DEPTH(DEP), .USEDW_W(9)) dut (
        .vga_clk(vga_clk), .reset(reset),
        .avs_address(avs_address), .avs_write(avs_write), .avs_read(avs_read),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .fifo_write(fifo_write), .fifo_writedata(fifo_writedata),
        .fifo_wrusedw(fifo_wrusedw), .fifo_clear(fifo_clear), .vsync_n(vsync_n)
    );

    always #5 vga_clk = ~vga_clk;

    int checks = 0, errors = 0;

    // Reference model state: frame base latched at each clear, request/write indices.
    logic [31:0] model_base = '0, act_base = '0, first_req_addr = '0, prev_addr = '0;
    int clear_cnt = 0, req_idx = 0, wr_idx = 0, wr_total = 0, last_frame_writes = -1;
    int stall_left = 0, hold_cnt = 0;
    bit beat_hold = 0, rand_wait = 0, rand_gap = 0, prev_stall = 0;
    logic [31:0] beatq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Avalon slave + FIFO-side monitor, all on the falling edge.
    always @(negedge vga_clk) begin
        logic wreq;
        if (prev_stall) begin
            hold_cnt++;
            chk("hold_read", {31'b0, avm_read}, 32'd1);
            chk("hold_addr", avm_address, prev_addr);
            chk("hold_bcnt", {25'b0, avm_burstcount}, BST);
        end
        wreq = 1'b0;
        if (avm_read) begin
            if (stall_left > 0) begin
                wreq = 1'b1;
                stall_left--;
            end else if (rand_wait && $urandom_range(0, 2) == 0) begin
                wreq = 1'b1;
            end
        end
        avm_waitrequest = wreq;
        prev_stall = avm_read && wreq;
        prev_addr  = avm_address;
        if (!beat_hold && beatq.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem_word(beatq.pop_front());
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
        end
        if (avm_read && !wreq) begin
            chk("req_addr", avm_address, act_base + 32'(32 * req_idx));
            if (req_idx == 0) first_req_addr = avm_address;
            req_idx++;
            for (int i = 0; i < BST; i++) beatq.push_back(avm_address + 32'(4 * i));
        end
        #1;
        if (fifo_clear) begin
            last_frame_writes = wr_idx;
            clear_cnt++;
            act_base = model_base;
            req_idx = 0;
            wr_idx = 0;
        end
        if (fifo_write) begin
            chk("wr_data", fifo_writedata, mem_word(act_base + 32'(4 * wr_idx)));
            wr_idx++;
            wr_total++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
        if (a == REG_BASE) model_base = d & ~32'h3;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic reg_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic vsync_pulse();
        vsync_n = 1'b0; tick(4); vsync_n = 1'b1;
    endtask

    task automatic wait_clear(input int prev);
        int n = 0;
        while (clear_cnt == prev && n < 500) begin tick(); n++; end
        chk("clear_seen", {31'b0, clear_cnt != prev}, 32'd1);
    endtask

    task automatic start_frame();
        int prev = clear_cnt;
        vsync_pulse();
        wait_clear(prev);
        chk("one_clear", clear_cnt, prev + 1);
    endtask

    task automatic wait_reqs(input int k);
        int n = 0;
        while (req_idx < k && n < 1000) begin tick(); n++; end
        chk("reqs_reached", {31'b0, req_idx >= k}, 32'd1);
    endtask

    task automatic wait_frame();
        int n = 0;
        while (wr_idx < FBW && n < 3000) begin tick(); n++; end
        tick(10);
        chk("frame_writes", wr_idx, FBW);
        chk("frame_reqs", req_idx, FBW / BST);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } reg_vec_t;

    initial begin
        reg_vec_t vecs[15];
        logic [31:0] d;
        int snap, prev;

        vecs[0]  = '{1'b0, REG_CTRL,   32'h0,        32'h0};
        vecs[1]  = '{1'b0, REG_BASE,   32'h0,        32'h0};
        vecs[2]  = '{1'b0, REG_STATUS, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, REG_FRAMES, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, REG_BASE,   32'h0000_1003, 32'h0};
        vecs[5]  = '{1'b0, REG_BASE,   32'h0,        32'h0000_1000};
        vecs[6]  = '{1'b1, REG_FRAMES, 32'h55,       32'h0};
        vecs[7]  = '{1'b0, REG_FRAMES, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, REG_STATUS, 32'h3,        32'h0};
        vecs[9]  = '{1'b0, REG_STATUS, 32'h0,        32'h0};
        vecs[10] = '{1'b1, REG_CTRL,   32'hFFFF_FFFE, 32'h0};
        vecs[11] = '{1'b0, REG_CTRL,   32'h0,        32'h0};
        vecs[12] = '{1'b1, REG_CTRL,   32'h1,        32'h0};
        vecs[13] = '{1'b0, REG_CTRL,   32'h0,        32'h1};
        vecs[14] = '{1'b0, REG_STATUS, 32'h0,        32'h0};

        tick(5);
        chk("rst_avm_read", {31'b0, avm_read}, 0);
        chk("rst_avm_addr", avm_address, 0);
        chk("rst_fifo_write", {31'b0, fifo_write}, 0);
        chk("rst_fifo_clear", {31'b0, fifo_clear}, 0);
        chk("rst_readdata", avs_readdata, 0);
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].data);
            else begin
                reg_read(vecs[i].addr, d);
                chk($sformatf("regvec%0d", i), d, vecs[i].exp);
            end
        end

        // Basic frame, zero-wait slave.
        reg_write(REG_BASE, 32'h1000);
        tick(3);
        start_frame();
        wait_frame();
        chk("f1_first_addr", first_req_addr, 32'h1000);
        reg_chk("f1_frames", REG_FRAMES, 32'd1);
        reg_chk("f1_status", REG_STATUS, 32'd0);

        // FIFO credit: 250 used blocks everything, 248 allows exactly one burst.
        fifo_wrusedw = 9'd250; beat_hold = 1;
        start_frame();
        tick(30);
        chk("credit_none", req_idx, 0);
        chk("credit_noread", {31'b0, avm_read}, 0);
        fifo_wrusedw = 9'd248;
        tick(30);
        chk("credit_one", req_idx, 1);
        fifo_wrusedw = 9'd0; beat_hold = 0;
        wait_frame();

        // Waitrequest held for five cycles on the first request.
        hold_cnt = 0; stall_left = 5;
        start_frame();
        wait_frame();
        chk("stall_holds", hold_cnt, 5);

        // Late frame: three bursts in flight, second vsync aborts.
        fifo_wrusedw = 9'd232; beat_hold = 1;
        start_frame();
        tick(40);
        chk("abort_reqs", req_idx, 3);
        prev = clear_cnt;
        vsync_pulse();
        tick(20);
        chk("abort_noreq", req_idx, 3);
        chk("abort_noclear", clear_cnt, prev);
        reg_chk("abort_status", REG_STATUS, 32'd3);
        fifo_wrusedw = 9'd0; beat_hold = 0;
        wait_clear(prev);
        chk("abort_discard", last_frame_writes, 0);
        wait_frame();
        chk("abort_restart", first_req_addr, 32'h1000);
        reg_chk("late_sticky", REG_STATUS, 32'd2);
        reg_write(REG_STATUS, 32'h2);
        reg_chk("late_w1c", REG_STATUS, 32'd0);

        // BASE written mid-frame only affects the next frame.
        start_frame();
        wait_reqs(2);
        reg_write(REG_BASE, 32'h2000);
        wait_frame();
        chk("base_old", first_req_addr, 32'h1000);
        start_frame();
        wait_frame();
        chk("base_new", first_req_addr, 32'h2000);

        // Randomized slave timing and frame bases.
        rand_wait = 1; rand_gap = 1;
        for (int f = 0; f < 4; f++) begin
            reg_write(REG_BASE, 32'($urandom_range(0, 4095)) << 5);
            start_frame();
            wait_frame();
            chk("rand_first", first_req_addr, model_base);
        end
        rand_wait = 0; rand_gap = 0;
        tick(20);
        reg_chk("frames_cnt", REG_FRAMES, 32'(clear_cnt & 16'hFFFF));

        // Enable dropped mid-fetch: no more writes, ends idle.
        start_frame();
        wait_reqs(3);
        reg_write(REG_CTRL, 32'h0);
        tick();
        snap = wr_total;
        tick(40);
        chk("dis_nowrite", wr_total, snap);
        chk("dis_noread", {31'b0, avm_read}, 0);
        reg_chk("dis_status", REG_STATUS, 32'd0);

        // Reset with two bursts outstanding; trailing beats must not be written.
        reg_write(REG_CTRL, 32'h1);
        fifo_wrusedw = 9'd240; beat_hold = 1;
        start_frame();
        tick(30);
        chk("rst_reqs", req_idx, 2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_base = '0;
        snap = wr_total;
        fifo_wrusedw = 9'd0; beat_hold = 0;
        tick(1);
        chk("rst2_readdata", avs_readdata, 0);
        tick(40);
        chk("rst2_nowrite", wr_total, snap);
        chk("rst2_noread", {31'b0, avm_read}, 0);
        chk("rst2_addr", avm_address, 0);
        chk("rst2_clear", {31'b0, fifo_clear}, 0);
        reg_chk("rst2_ctrl", REG_CTRL, 32'd0);
        reg_chk("rst2_base", REG_BASE, 32'd0);
        reg_chk("rst2_status", REG_STATUS, 32'd0);
        reg_chk("rst2_frames", REG_FRAMES, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_4bit_fetch.md
# vga_4bit_fetch

Frame-buffer fetch controller for the 4-bit VGA output path. Runs an Avalon-MM burst read master that streams 32-bit frame-buffer words (8 pixels × 4 bits) into the mixed-width pixel FIFO (32-bit write, 4-bit read) drained by the VGA timing/graph block. Issues requests only within FIFO credit, realigns to each frame on the vertical sync pulse and exposes a small Avalon-MM control/status slave.

## Interface
- FB_WORDS, 38400: 32-bit words per frame (640×480/8); multiple of BURST
- BURST, 8: words per read burst, power of two, 1..64
- FIFO_DEPTH, 256: pixel FIFO capacity in 32-bit words
- USEDW_W, 9: width of fifo_wrusedw
- vga_clk  in  1  single clock for the whole block
- reset  in  1  synchronous, active-high
- avs_address  in  2  control register index
- avs_write / avs_read  in  1  slave strobes, no waitrequest
- avs_writedata  in  32
- avs_readdata  out  32  valid the cycle after avs_read (read latency 1)
- avm_address  out  32  byte address, burst aligned
- avm_read  out  1
- avm_burstcount  out  7  constant BURST
- avm_waitrequest  in  1
- avm_readdata  in  32
- avm_readdatavalid  in  1
- fifo_write  out  1  equals avm_readdatavalid while not discarding
- fifo_writedata  out  32  avm_readdata, pixel 0 in bits [3:0]
- fifo_wrusedw  in  USEDW_W  FIFO fill level, words
- fifo_clear  out  1  one-cycle synchronous FIFO flush
- vsync_n  in  1  active-low vertical sync from the VGA timing block

## Operation
- Registers: 0 CTRL (bit0 enable); 1 BASE (byte address, bits [1:0] ignored); 2 STATUS (bit0 busy, bit1 late sticky, write 1 clears); 3 FRAMES (16-bit frame counter, read-only, wraps 0xFFFF→0).
- Frame start = falling edge of vsync_n (registered; first cycle low after high).
- FSM: IDLE → (enable=1) SYNC → (frame start) FLUSH → (outstanding=0) CLEAR → FETCH → (requested=FB_WORDS) DRAIN → (outstanding=0) SYNC.
- IDLE: avm_read=0; enable=0 in any state returns to IDLE once outstanding=0, incoming data discarded.
- CLEAR: one cycle, fifo_clear=1, BASE copied to active address, word counter cleared, FRAMES incremented.
- FETCH: assert avm_read when credit holds: fifo_wrusedw + outstanding + BURST ≤ FIFO_DEPTH. Address, read and burstcount held stable while avm_waitrequest=1. On acceptance: outstanding += BURST, address += 4·BURST, requested += BURST.
- outstanding decrements by 1 per avm_readdatavalid; acceptance and beat in the same cycle net +BURST−1.
- Frame start while in FETCH or DRAIN: set late, stop issuing, go FLUSH; beats still returning for the aborted frame are discarded (fifo_write=0) until outstanding=0.
- BASE writes take effect only at the next CLEAR.
- busy=1 in any state except IDLE and SYNC.

## Timing
- Reset values: avm_read=0, avm_address=0, fifo_write=0, fifo_clear=0, avs_readdata=0, CTRL=0, BASE=0, STATUS=0, FRAMES=0, FSM=IDLE, outstanding=0.
- fifo_write/fifo_writedata combinational from avm_readdatavalid/avm_readdata (zero latency).
- First avm_read ≥1 cycle after fifo_clear; credit check uses registered outstanding.
- Outstanding counter width ≥ log2(FIFO_DEPTH)+1; never exceeds FIFO_DEPTH.
- Reset mid-burst: state cleared immediately; beats arriving after reset are not written (FSM in IDLE).

## Structure
- Shared package/include: register offsets, CTRL/STATUS bit positions, FSM state encodings, default FB_WORDS/BURST.
- One natural sub-module: vga_4bit_fetch_regs (Avalon slave register file, late W1C, read mux).

## Test plan
- Enable, BASE=0x1000, zero-wait slave, FB_WORDS=64, BURST=8: one vsync → fifo_clear once, 8 bursts at 0x1000..0x10E0 step 0x20, 64 fifo_writes, FRAMES=1, late=0.
- fifo_wrusedw held at 250, DEPTH 256: no avm_read; lower to 248 → exactly one burst, then stall until usedw falls.
- avm_waitrequest high 5 cycles on a request: address/read/burstcount constant for all 5, accepted once.
- Second vsync after 3 of 8 bursts: late=1, no further requests, in-flight beats not written, fifo_clear after drain, address restarts at BASE; W1C of 0x2 clears late.
- BASE changed mid-frame to 0x2000: current frame continues at old base; next frame starts at 0x2000.
- Enable cleared mid-FETCH then reset mid-burst: IDLE, avm_read=0, all outputs at reset values, trailing beats not written.
